// File: rtl/add8_acc_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : add8_acc_seq_if
// Brief    : Operand stream, adder-cell and result bus for add8_acc_seq.
//            The sat_cnt signal exists only when ADD8_ACC_SAT_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface add8_acc_seq_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             sign_mode;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [3:0]       add_src0;
    logic [3:0]       add_src1;
    logic [3:0]       add_src2;
    logic             add_sign_s1;
    logic             add_sign_s2;
    logic             add_sign_d;
    logic [3:0]       add_dst0;
    logic [3:0]       add_dst1;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             sat_flag;
    logic             busy;
`ifdef ADD8_ACC_SAT_CNT_EN
    logic [7:0]       sat_cnt;
`endif

    // master: operand source, result consumer and adder cell
    modport master (
`ifdef ADD8_ACC_SAT_CNT_EN
        input  sat_cnt,
`endif
        output start, len, sign_mode, in_valid, in_data, out_ready,
        output add_dst0, add_dst1,
        input  in_ready, out_valid, out_data, sat_flag, busy,
        input  add_src0, add_src1, add_src2, add_sign_s1, add_sign_s2, add_sign_d
    );

    // slave: the accumulator controller
    modport slave (
`ifdef ADD8_ACC_SAT_CNT_EN
        output sat_cnt,
`endif
        input  start, len, sign_mode, in_valid, in_data, out_ready,
        input  add_dst0, add_dst1,
        output in_ready, out_valid, out_data, sat_flag, busy,
        output add_src0, add_src1, add_src2, add_sign_s1, add_sign_s2, add_sign_d
    );
endinterface
`default_nettype wire

// File: rtl/add8_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : add8_acc_seq
// Brief    : Burst accumulator driving an external 8-bit nibble saturating
//            adder; returns one saturated 8-bit total per burst.
//            Optional ADD8_ACC_SAT_CNT_EN adds a clipped-beat counter (sat_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module add8_acc_seq #(
    parameter int CNT_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    add8_acc_seq_if.slave bus
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ACC  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [7:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_sign;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic             r_sat_flag;
    logic             r_busy;
`ifdef ADD8_ACC_SAT_CNT_EN
    logic [7:0]       r_sat_cnt;
`endif

    logic [7:0] w_ext;
    logic [7:0] w_wrap;
    logic [7:0] w_dst;
    logic       w_clip;
    logic       w_fire;
    logic       w_last;

    // Low 8 bits of the 9-bit extended sum equal the plain 8-bit wrap-around
    // sum; any difference from the adder output means the adder clamped.
    assign w_ext  = r_sign ? {{4{bus.in_data[3]}}, bus.in_data} : {4'b0000, bus.in_data};
    assign w_wrap = r_acc + w_ext;
    assign w_dst  = {bus.add_dst1, bus.add_dst0};
    assign w_clip = (w_wrap != w_dst);
    assign w_fire = (r_state == c_ACC) && bus.in_valid && r_in_ready;
    assign w_last = (r_cnt == (r_len - c_ONE));

    assign bus.add_src0    = r_acc[3:0];
    assign bus.add_src1    = r_acc[7:4];
    assign bus.add_src2    = bus.in_data;
    assign bus.add_sign_s1 = r_sign;
    assign bus.add_sign_s2 = r_sign;
    assign bus.add_sign_d  = 1'b0;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.sat_flag  = r_sat_flag;
    assign bus.busy      = r_busy;
`ifdef ADD8_ACC_SAT_CNT_EN
    assign bus.sat_cnt   = r_sat_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_acc       <= 8'h00;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sign      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_sat_flag  <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ADD8_ACC_SAT_CNT_EN
            r_sat_cnt   <= 8'h00;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_acc      <= 8'h00;
                        r_cnt      <= '0;
                        r_len      <= bus.len;
                        r_sign     <= bus.sign_mode;
                        r_sat_flag <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef ADD8_ACC_SAT_CNT_EN
                        r_sat_cnt  <= 8'h00;
`endif
                        if (bus.len != '0) begin
                            r_state    <= c_ACC;
                            r_in_ready <= 1'b1;
                        end else begin
                            // Empty burst: report a zero total straight away
                            r_state     <= c_DONE;
                            r_out_valid <= 1'b1;
                            r_out_data  <= 8'h00;
                        end
                    end
                end

                c_ACC: begin
                    if (w_fire) begin
                        r_acc <= w_dst;
                        r_cnt <= r_cnt + c_ONE;
                        if (w_clip) begin
                            r_sat_flag <= 1'b1;
`ifdef ADD8_ACC_SAT_CNT_EN
                            if (r_sat_cnt != 8'hFF) begin
                                r_sat_cnt <= r_sat_cnt + 8'd1;
                            end
`endif
                        end
                        if (w_last) begin
                            r_state     <= c_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_dst;
                        end
                    end
                end

                c_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= c_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= c_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_add8_acc_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_add8_acc_seq
// Brief    : Scoreboard bench for add8_acc_seq with a behavioural adder cell.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add8_acc_seq;
    logic clk;
    logic rst;

    add8_acc_seq_if #(.CNT_W(8)) bus ();

    add8_acc_seq #(.CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural saturating adder cell
    logic [7:0] m_acc;
    int         m_sum;
    logic [7:0] m_res;
    always_comb begin
        m_acc = {bus.add_src1, bus.add_src0};
        m_sum = 0;
        if (bus.add_sign_s1) begin
            m_sum = int'($signed(m_acc)) + int'($signed(bus.add_src2));
            if (m_sum > 127) m_sum = 127;
            else if (m_sum < -128) m_sum = -128;
        end else begin
            m_sum = int'(m_acc) + int'(bus.add_src2);
            if (m_sum > 255) m_sum = 255;
        end
        m_res = m_sum[7:0];
    end
    assign bus.add_dst0 = m_res[3:0];
    assign bus.add_dst1 = m_res[7:4];

    typedef struct packed {
        logic [7:0] data;
        logic       sat;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] vec[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever a result is accepted
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                chk("result_expected", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("sat_flag", bus.sat_flag, e.sat);
`ifdef ADD8_ACC_SAT_CNT_EN
                    chk("sat_cnt", bus.sat_cnt, e.cnt);
`endif
                end
            end
        end
    end

    task automatic run_burst(input logic sgn, input int n, input bit rv, input bit hold,
                             input logic [7:0] ed, input logic ed_sat, input logic [7:0] ecnt);
        exp_t e;
        int   i;
        int   guard;
        bit   took;
        e.data = ed;
        e.sat  = ed_sat;
        e.cnt  = ecnt;
        sb.push_back(e);
        bus.out_ready = !hold;
        bus.start     = 1'b1;
        bus.len       = 8'(n);
        bus.sign_mode = sgn;
        @(posedge clk); #1;
        // Changes after start must not affect the running burst
        bus.start     = 1'b0;
        bus.len       = 8'hAA;
        bus.sign_mode = !sgn;
        if (n == 0) chk("len0_valid_next_cycle", bus.out_valid, 1);
        i = 0;
        guard = 0;
        while (i < n && guard < 2000) begin
            bus.in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_data  = vec[i];
            @(negedge clk);
            chk("no_early_valid", bus.out_valid, 0);
            chk("src2_pass", bus.add_src2, vec[i]);
            chk("sign_latched", bus.add_sign_s1, sgn);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (took) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        chk("beats_accepted", i, n);
        if (n > 0) chk("valid_after_last_beat", bus.out_valid, 1);
        if (hold) begin
            bus.start = 1'b1;
            bus.len   = 8'd0;
            repeat (5) begin
                @(negedge clk);
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_data", bus.out_data, ed);
                chk("hold_in_ready", bus.in_ready, 0);
            end
            @(posedge clk); #1;
            bus.start     = 1'b0;
            bus.out_ready = 1'b1;
        end
        guard = 0;
        while ((bus.out_valid || bus.busy) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("returned_idle", bus.busy, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len       = 8'd0;
        bus.sign_mode = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_acc", {bus.add_src1, bus.add_src0}, 0);
        chk("sign_d_tied", bus.add_sign_d, 0);
`ifdef ADD8_ACC_SAT_CNT_EN
        chk("rst_sat_cnt", bus.sat_cnt, 0);
`endif
        @(posedge clk); #1;

        vec = '{4'h3, 4'h4, 4'h5};
        run_burst(1'b0, 3, 0, 0, 8'h0C, 1'b0, 8'd0);

        vec = {};
        for (int k = 0; k < 20; k++) vec.push_back(4'hF);
        run_burst(1'b0, 20, 0, 0, 8'hFF, 1'b1, 8'd3);

        vec = {};
        for (int k = 0; k < 20; k++) vec.push_back(4'h7);
        run_burst(1'b1, 20, 0, 0, 8'h7F, 1'b1, 8'd2);

        vec = {};
        for (int k = 0; k < 20; k++) vec.push_back(4'h8);
        run_burst(1'b1, 20, 0, 0, 8'h80, 1'b1, 8'd4);

        // Saturated sum keeps accumulating: 0x7F + (-1) = 0x7E
        vec = {};
        for (int k = 0; k < 19; k++) vec.push_back(4'h7);
        vec.push_back(4'hF);
        run_burst(1'b1, 20, 0, 0, 8'h7E, 1'b1, 8'd1);

        vec = '{4'h7, 4'h7, 4'h8};
        run_burst(1'b1, 3, 0, 0, 8'h06, 1'b0, 8'd0);

        vec = {};
        run_burst(1'b0, 0, 0, 0, 8'h00, 1'b0, 8'd0);

        vec = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        run_burst(1'b0, 5, 1, 1, 8'h0F, 1'b0, 8'd0);

        // Reset in the middle of a burst: nothing may be emitted
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.len       = 8'd4;
        bus.sign_mode = 1'b0;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h1;
        @(posedge clk); #1;
        bus.in_data = 4'h2;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_data", bus.out_data, 0);
        chk("abort_sat_flag", bus.sat_flag, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_acc", {bus.add_src1, bus.add_src0}, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_result", bus.out_valid, 0);

        vec = '{4'h1};
        run_burst(1'b0, 1, 0, 0, 8'h01, 1'b0, 8'd0);

        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
